// File: rtl/inst_fetcher.sv
// inst_fetcher: fetch stage with static next-PC prediction, JALR stall and a small instruction queue
module inst_fetcher #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          QDEPTH_LOG = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic [31:0] _clear_pc,
    input  logic        _stall_recover,
    input  logic [31:0] _recover_pc,
    input  logic        _inst_ready_in_Mem2Fetcher,
    input  logic [31:0] _inst_in_Mem2Fetcher,
    output logic [31:0] _pc_Fetcher2Mem,
    output logic        _InstFetcher_need_inst,
    output logic        _stall_set,
    output logic        _inst_valid_Fetcher2Decoder,
    output logic [31:0] _inst_Fetcher2Decoder,
    output logic [31:0] _pc_Fetcher2Decoder,
    output logic        _pred_taken_Fetcher2Decoder,
    input  logic        _decoder_ready
);
    localparam int DEPTH = 1 << QDEPTH_LOG;
    localparam int CW = QDEPTH_LOG + 1;
    typedef enum logic {FETCH, STALL} state_t;
    state_t state_q, state_d;
    logic [31:0] pc_q, next_pc, j_imm, b_imm, inst;
    logic need_q, stall_set_q, accept, pop, is_jal, is_br, is_jalr, pred;
    logic [31:0] q_pc_q [DEPTH];
    logic [31:0] q_inst_q [DEPTH];
    logic [DEPTH-1:0] q_pred_q;
    logic [QDEPTH_LOG-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    assign inst = _inst_in_Mem2Fetcher;
    // Decode the returned instruction into a predicted next PC and derive push/pop and next state
    always_comb begin
        j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        is_jal = inst[6:0] == 7'b1101111;
        is_br = inst[6:0] == 7'b1100011;
        is_jalr = inst[6:0] == 7'b1100111;
        pred = is_jal || (is_br && inst[31]);
        next_pc = is_jal ? pc_q + j_imm : (is_br && inst[31]) ? pc_q + b_imm : is_jalr ? pc_q : pc_q + 32'd4;
        accept = state_q == FETCH && need_q && _inst_ready_in_Mem2Fetcher && count_q != CW'(DEPTH);
        pop = count_q != '0 && _decoder_ready;
        count_d = count_q + CW'(accept) - CW'(pop);
        state_d = state_q == STALL ? (_stall_recover ? FETCH : STALL) : (accept && is_jalr ? STALL : FETCH);
    end
    // PC, fetch FSM, registered request/stall outputs and the circular instruction queue
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q <= RESET_PC;
            state_q <= FETCH;
            need_q <= 1'b0;
            stall_set_q <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (_clear) begin
                pc_q <= _clear_pc;
                state_q <= FETCH;
                need_q <= 1'b1;
                stall_set_q <= 1'b0;
                head_q <= '0;
                tail_q <= '0;
                count_q <= '0;
            end else begin
                if (accept) begin
                    q_pc_q[tail_q] <= pc_q;
                    q_inst_q[tail_q] <= inst;
                    q_pred_q[tail_q] <= pred;
                    tail_q <= tail_q + QDEPTH_LOG'(1);
                end
                if (pop) head_q <= head_q + QDEPTH_LOG'(1);
                if (state_q == STALL && _stall_recover) pc_q <= _recover_pc;
                else if (accept) pc_q <= next_pc;
                state_q <= state_d;
                count_q <= count_d;
                stall_set_q <= accept && is_jalr;
                need_q <= state_d == FETCH && count_d != CW'(DEPTH);
            end
        end
    end
    assign _pc_Fetcher2Mem = pc_q;
    assign _InstFetcher_need_inst = need_q;
    assign _stall_set = stall_set_q;
    assign _inst_valid_Fetcher2Decoder = count_q != '0;
    assign _inst_Fetcher2Decoder = _inst_valid_Fetcher2Decoder ? q_inst_q[head_q] : '0;
    assign _pc_Fetcher2Decoder = _inst_valid_Fetcher2Decoder ? q_pc_q[head_q] : '0;
    assign _pred_taken_Fetcher2Decoder = _inst_valid_Fetcher2Decoder ? q_pred_q[head_q] : 1'b0;
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed scenarios plus randomized traffic checked against a queue-based reference model
module tb_inst_fetcher;
    logic clk = 0, rst = 0, rdy = 1, clr = 0, rec = 0, mresp = 0, dready = 0;
    logic [31:0] clr_pc = 0, rec_pc = 0, minst = 0;
    logic [31:0] pc_o, dinst_o, dpc_o;
    logic need_o, sset_o, dvalid_o, dpred_o;
    int n_cmp = 0, n_err = 0;
    typedef struct {logic [31:0] pc; logic [31:0] inst; logic pred;} ent_t;
    ent_t m_q[$];
    logic [31:0] m_pc = 0;
    logic m_stall = 0, m_need = 0, m_sset = 0;

    inst_fetcher dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        ._clear(clr), ._clear_pc(clr_pc),
        ._stall_recover(rec), ._recover_pc(rec_pc),
        ._inst_ready_in_Mem2Fetcher(mresp), ._inst_in_Mem2Fetcher(minst),
        ._pc_Fetcher2Mem(pc_o), ._InstFetcher_need_inst(need_o), ._stall_set(sset_o),
        ._inst_valid_Fetcher2Decoder(dvalid_o), ._inst_Fetcher2Decoder(dinst_o),
        ._pc_Fetcher2Decoder(dpc_o), ._pred_taken_Fetcher2Decoder(dpred_o),
        ._decoder_ready(dready)
    );

    always #5 clk = ~clk;

    // Static prediction computed from the immediate's numeric value
    function automatic void predict(input logic [31:0] pc, input logic [31:0] in, output logic [31:0] npc,
                                    output logic p, output logic jalr);
        logic [31:0] imm;
        jalr = in[6:0] == 7'b1100111;
        p = 1'b0;
        npc = pc + 32'd4;
        if (in[6:0] == 7'b1101111) begin
            imm = 32'(in[30:21]) * 2 + 32'(in[20]) * 2048 + 32'(in[19:12]) * 4096 - (in[31] ? 32'h0010_0000 : 32'h0);
            npc = pc + imm;
            p = 1'b1;
        end else if (in[6:0] == 7'b1100011 && in[31]) begin
            imm = 32'(in[11:8]) * 2 + 32'(in[30:25]) * 32 + 32'(in[7]) * 2048 - 32'd4096;
            npc = pc + imm;
            p = 1'b1;
        end else if (jalr) begin
            npc = pc;
        end
    endfunction

    // Advance the reference model with the current inputs, then clock the DUT
    task automatic step();
        logic acc, jalr, p;
        logic [31:0] npc;
        ent_t e;
        if (rst) begin
            m_q.delete(); m_pc = 32'h0; m_stall = 0; m_need = 0; m_sset = 0;
        end else if (rdy) begin
            if (clr) begin
                m_q.delete(); m_pc = clr_pc; m_stall = 0; m_sset = 0;
            end else begin
                acc = !m_stall && m_need && mresp && m_q.size() < 4;
                if (m_q.size() > 0 && dready) void'(m_q.pop_front());
                m_sset = 0;
                if (acc) begin
                    predict(m_pc, minst, npc, p, jalr);
                    e.pc = m_pc; e.inst = minst; e.pred = p;
                    m_q.push_back(e);
                    m_pc = npc; m_stall = jalr; m_sset = jalr;
                end else if (m_stall && rec) begin
                    m_pc = rec_pc; m_stall = 0;
                end
            end
            m_need = !m_stall && m_q.size() < 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic [31:0] in);
        mresp = 1; minst = in; step(); mresp = 0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        clr = 1; clr_pc = pc; step(); clr = 0;
    endtask

    task automatic drain(input int n);
        dready = 1;
        repeat (n) step();
        dready = 0;
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", pc_o, 32'h0); end
        n_cmp++; if (need_o !== 1'b0) begin n_err++; $display("FAIL reset_need got %b want 0", need_o); end
        n_cmp++; if (sset_o !== 1'b0) begin n_err++; $display("FAIL reset_stall_set got %b want 0", sset_o); end
        n_cmp++; if (dvalid_o !== 1'b0 || dinst_o !== 32'h0 || dpc_o !== 32'h0) begin n_err++; $display("FAIL reset_head got v=%b i=%h p=%h want 0", dvalid_o, dinst_o, dpc_o); end
        rst = 0; step();
        n_cmp++; if (need_o !== 1'b1) begin n_err++; $display("FAIL reset_release_need got %b want 1", need_o); end
    endtask

    task automatic test_sequential();
        dready = 0;
        repeat (3) resp(32'h0000_0013);
        n_cmp++; if (pc_o !== 32'hC) begin n_err++; $display("FAIL seq_pc got %h want %h", pc_o, 32'hC); end
        n_cmp++; if (dvalid_o !== 1'b1) begin n_err++; $display("FAIL seq_valid got %b want 1", dvalid_o); end
        dready = 1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (dpc_o !== 32'(4 * i) || dinst_o !== 32'h13 || dpred_o !== 1'b0) begin n_err++; $display("FAIL seq_pop%0d got pc=%h i=%h p=%b want pc=%h i=13 p=0", i, dpc_o, dinst_o, dpred_o, 4 * i); end
            step();
        end
        dready = 0;
        n_cmp++; if (dvalid_o !== 1'b0) begin n_err++; $display("FAIL seq_empty got %b want 0", dvalid_o); end
    endtask

    task automatic test_jal();
        redirect(32'h10);
        resp(32'h0080_006F);
        n_cmp++; if (pc_o !== 32'h18) begin n_err++; $display("FAIL jal_pc got %h want %h", pc_o, 32'h18); end
        n_cmp++; if (dpc_o !== 32'h10 || dpred_o !== 1'b1) begin n_err++; $display("FAIL jal_head got pc=%h p=%b want pc=10 p=1", dpc_o, dpred_o); end
        drain(1);
    endtask

    task automatic test_branch();
        redirect(32'h20);
        resp(32'hFE00_0EE3);
        n_cmp++; if (pc_o !== 32'h1C) begin n_err++; $display("FAIL bwd_br_pc got %h want %h", pc_o, 32'h1C); end
        n_cmp++; if (dpred_o !== 1'b1) begin n_err++; $display("FAIL bwd_br_pred got %b want 1", dpred_o); end
        drain(1);
        redirect(32'h20);
        resp(32'h0000_0463);
        n_cmp++; if (pc_o !== 32'h24) begin n_err++; $display("FAIL fwd_br_pc got %h want %h", pc_o, 32'h24); end
        n_cmp++; if (dpred_o !== 1'b0 || dvalid_o !== 1'b1) begin n_err++; $display("FAIL fwd_br_pred got p=%b v=%b want p=0 v=1", dpred_o, dvalid_o); end
        drain(1);
    endtask

    task automatic test_jalr();
        redirect(32'h40);
        resp(32'h0000_8067);
        n_cmp++; if (sset_o !== 1'b1 || need_o !== 1'b0) begin n_err++; $display("FAIL jalr_enter got sset=%b need=%b want 1 0", sset_o, need_o); end
        n_cmp++; if (pc_o !== 32'h40) begin n_err++; $display("FAIL jalr_pc got %h want %h", pc_o, 32'h40); end
        step();
        n_cmp++; if (sset_o !== 1'b0 || need_o !== 1'b0) begin n_err++; $display("FAIL jalr_pulse got sset=%b need=%b want 0 0", sset_o, need_o); end
        resp(32'h0000_0013);
        drain(1);
        n_cmp++; if (dvalid_o !== 1'b0 || pc_o !== 32'h40) begin n_err++; $display("FAIL jalr_drop got v=%b pc=%h want v=0 pc=40", dvalid_o, pc_o); end
        rec = 1; rec_pc = 32'h100; step(); rec = 0;
        n_cmp++; if (pc_o !== 32'h100 || need_o !== 1'b1) begin n_err++; $display("FAIL jalr_recover got pc=%h need=%b want 100 1", pc_o, need_o); end
        resp(32'h0000_0013);
        n_cmp++; if (dpc_o !== 32'h100 || pc_o !== 32'h104) begin n_err++; $display("FAIL jalr_resume got head=%h pc=%h want 100 104", dpc_o, pc_o); end
        drain(1);
    endtask

    task automatic test_full();
        redirect(32'h0);
        repeat (4) resp(32'h0000_0013);
        n_cmp++; if (need_o !== 1'b0 || pc_o !== 32'h10) begin n_err++; $display("FAIL full_need got need=%b pc=%h want 0 10", need_o, pc_o); end
        resp(32'h0000_0013);
        n_cmp++; if (pc_o !== 32'h10 || dpc_o !== 32'h0) begin n_err++; $display("FAIL full_drop got pc=%h head=%h want 10 0", pc_o, dpc_o); end
        drain(1);
        n_cmp++; if (need_o !== 1'b1 || dpc_o !== 32'h4) begin n_err++; $display("FAIL full_pop got need=%b head=%h want 1 4", need_o, dpc_o); end
        drain(3);
        n_cmp++; if (dvalid_o !== 1'b0) begin n_err++; $display("FAIL full_drain got %b want 0", dvalid_o); end
    endtask

    task automatic test_clear();
        redirect(32'h40);
        resp(32'h0000_0013);
        resp(32'h0000_8067);
        clr = 1; clr_pc = 32'h200; mresp = 1; minst = 32'h13; step(); clr = 0; mresp = 0;
        n_cmp++; if (dvalid_o !== 1'b0 || pc_o !== 32'h200) begin n_err++; $display("FAIL clear_state got v=%b pc=%h want 0 200", dvalid_o, pc_o); end
        n_cmp++; if (sset_o !== 1'b0 || need_o !== 1'b1) begin n_err++; $display("FAIL clear_ctrl got sset=%b need=%b want 0 1", sset_o, need_o); end
        resp(32'h0000_0013);
        rdy = 0; mresp = 1; minst = 32'h0080_006F; dready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc_o !== 32'h204 || need_o !== 1'b1 || dvalid_o !== 1'b1 || dpc_o !== 32'h200 || sset_o !== 1'b0) begin n_err++; $display("FAIL rdy_hold%0d got pc=%h need=%b v=%b head=%h sset=%b want 204 1 1 200 0", i, pc_o, need_o, dvalid_o, dpc_o, sset_o); end
        end
        rdy = 1; mresp = 0; dready = 0;
        resp(32'h0000_8067);
        rst = 1; step(); rst = 0;
        n_cmp++; if (pc_o !== 32'h0 || dvalid_o !== 1'b0 || need_o !== 1'b0 || sset_o !== 1'b0) begin n_err++; $display("FAIL stall_reset got pc=%h v=%b need=%b sset=%b want 0 0 0 0", pc_o, dvalid_o, need_o, sset_o); end
        step();
        n_cmp++; if (need_o !== 1'b1) begin n_err++; $display("FAIL stall_reset_need got %b want 1", need_o); end
    endtask

    task automatic test_random();
        logic [31:0] r, e_pc, e_inst;
        logic [6:0] op;
        logic e_pred, e_v;
        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            case ($urandom_range(0, 4))
                0: op = 7'h13;
                1: op = 7'h6F;
                2: op = 7'h63;
                3: op = 7'h67;
                default: op = 7'h33;
            endcase
            minst = {r[31:7], op};
            mresp = 1'($urandom_range(0, 1));
            dready = $urandom_range(0, 2) != 0;
            rdy = $urandom_range(0, 9) != 0;
            clr = $urandom_range(0, 24) == 0;
            clr_pc = $urandom();
            rec = $urandom_range(0, 3) == 0;
            rec_pc = $urandom();
            rst = $urandom_range(0, 99) == 0;
            step();
            e_v = m_q.size() > 0;
            e_pc = e_v ? m_q[0].pc : 32'h0;
            e_inst = e_v ? m_q[0].inst : 32'h0;
            e_pred = e_v ? m_q[0].pred : 1'b0;
            n_cmp++; if (pc_o !== m_pc || need_o !== m_need || sset_o !== m_sset) begin n_err++; $display("FAIL rand_ctrl c%0d got pc=%h need=%b sset=%b want %h %b %b", i, pc_o, need_o, sset_o, m_pc, m_need, m_sset); end
            n_cmp++; if (dvalid_o !== e_v || dpc_o !== e_pc || dinst_o !== e_inst || dpred_o !== e_pred) begin n_err++; $display("FAIL rand_head c%0d got v=%b pc=%h i=%h p=%b want %b %h %h %b", i, dvalid_o, dpc_o, dinst_o, dpred_o, e_v, e_pc, e_inst, e_pred); end
        end
        rst = 0; rdy = 1; clr = 0; rec = 0; mresp = 0; dready = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jal();
        test_branch();
        test_jalr();
        test_full();
        test_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end fetch stage directly upstream of the memory controller's instruction port.
- Drives the fetch PC and request to the controller/ICache path, accepts the returned 32-bit instruction, and applies static next-PC prediction.
- Buffers fetched instructions in a small FIFO and hands them to the decoder over a valid/ready handshake.
- Stalls on JALR until the ROB resolves its target; discards all state on a pipeline clear.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.
- QDEPTH_LOG, 2, log2 of instruction-queue depth (4 entries).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low, all state holds
- _clear  input  1  ROB misprediction flush
- _clear_pc  input  32  redirect PC accompanying _clear
- _stall_recover  input  1  ROB resolved pending JALR
- _recover_pc  input  32  JALR target accompanying _stall_recover
- _inst_ready_in_Mem2Fetcher  input  1  one-cycle pulse: instruction valid
- _inst_in_Mem2Fetcher  input  32  returned instruction
- _pc_Fetcher2Mem  output  32  fetch address
- _InstFetcher_need_inst  output  1  request outstanding
- _stall_set  output  1  one-cycle pulse when JALR is fetched
- _inst_valid_Fetcher2Decoder  output  1  queue head valid
- _inst_Fetcher2Decoder  output  32  head instruction
- _pc_Fetcher2Decoder  output  32  head PC
- _pred_taken_Fetcher2Decoder  output  1  head predicted taken
- _decoder_ready  input  1  decoder consumes head this cycle

Behaviour:
- Clock and reset: one clock, clk_in; synchronous active-high reset rst_in. All state updates only on posedge clk_in.
- Reset values: pc = RESET_PC, state = FETCH, queue empty, all outputs low except _pc_Fetcher2Mem = RESET_PC.
- rdy_in low: no state change. Outputs hold their last values.
- FSM states:
  - FETCH: _InstFetcher_need_inst = 1 while the queue is not full. If the queue is full, the request is deasserted and the PC holds.
  - STALL: no request issued; waiting for _stall_recover.
- FETCH, on _inst_ready_in_Mem2Fetcher = 1:
  - Push {pc, inst, pred} into the queue.
  - Compute next PC from the instruction (opcode = inst[6:0]):
    - JAL (1101111): pc + sext(J-imm); pred = 1.
    - BRANCH (1100011): if B-imm is negative (inst[31] = 1), next = pc + sext(B-imm) and pred = 1. Otherwise next = pc + 4 and pred = 0.
    - JALR (1100111): push, pulse _stall_set for exactly 1 cycle, go to STALL; pc is not advanced.
    - All other opcodes: pc + 4; pred = 0.
  - _pc_Fetcher2Mem takes the new PC on the cycle after the pulse.
- PC arithmetic: 32-bit wraparound. Immediates are sign-extended with the low bit 0.
- Ignored responses: a response pulse arriving in STALL, or while _InstFetcher_need_inst = 0, is dropped.
- STALL: on _stall_recover, pc = _recover_pc and state = FETCH. Fetch restarts the next cycle.
- Queue:
  - Circular buffer of 2^QDEPTH_LOG entries with a count register.
  - Pop when _inst_valid_Fetcher2Decoder & _decoder_ready.
  - Simultaneous push and pop: count unchanged. Pop on empty and push on full are never performed.
  - Full check uses count == depth, so a pop in the same cycle does not allow a push.
- _clear (highest priority, above _stall_recover and push/pop):
  - Empty the queue, pc = _clear_pc, state = FETCH.
  - Any response arriving in the same cycle is discarded.
  - _stall_set is not pulsed.
- Reset during STALL or with a full queue returns to the reset values, same as power-up.
- Head outputs are driven combinationally from the queue head. When the queue is empty, _inst_valid_Fetcher2Decoder = 0 and the data outputs are don't-care (driven 0).

Test Plan:
- Reset then sequential fetch: responses for 0x00000013 at pc 0, 4, 8 → queue holds PCs 0, 4, 8; _pc_Fetcher2Mem = 0xC; decoder pops in order with pred = 0.
- JAL at pc 0x10 with inst 0x0080006F (imm +8) → pushed with pred = 1; next fetch PC = 0x18.
- Backward branch: inst 0xFE000EE3 at pc 0x20 (imm −4) → pred = 1, next PC 0x1C. Forward branch 0x00000463 at 0x20 → pred = 0, next PC 0x24.
- JALR 0x00008067 at pc 0x40 → _stall_set high for 1 cycle; no requests while in STALL; _stall_recover with _recover_pc = 0x100 → fetch resumes at 0x100.
- Queue full: _decoder_ready = 0, 4 responses → _InstFetcher_need_inst drops to 0; a single pop re-enables the request one cycle later; a 5th pulse sent while full is dropped.
- _clear with _clear_pc = 0x200 in the same cycle as a response and a pending STALL → queue empty, state FETCH, next _pc_Fetcher2Mem = 0x200, dropped response not visible to decoder; holding rdy_in = 0 for 3 cycles freezes all outputs.
